// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: shared FSM state type and burst-counter width for ser_arbiter.
package ser_arb_pkg;
    localparam int CNT_W = 8;
    typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/ser_arbiter_if.sv
// ser_arbiter_if: requester-side and serializer-side handshake bundle of ser_arbiter.
interface ser_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 20
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]         ser_data_o;
    logic                     ser_valid_o;
    logic                     ser_ready_i;
    logic [IW-1:0]            grant_o;
    logic                     busy_o;
    modport master (
        output req_valid_i, req_data_i, ser_ready_i,
        input  req_ready_o, ser_data_o, ser_valid_o, grant_o, busy_o
    );
    modport slave (
        input  req_valid_i, req_data_i, ser_ready_i,
        output req_ready_o, ser_data_o, ser_valid_o, grant_o, busy_o
    );
endinterface

// File: rtl/ser_arbiter_rr_pick.sv
// rr_pick: first set request scanning upward from ptr with wrap, plus any-request flag.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               any
);
    logic [IW-1:0] idx;
    assign any = |req;
    // Scan downward so the lowest offset from ptr is written last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) grant = idx;
        end
    end
endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter: round-robin burst arbiter feeding one serializer word stream.
// Define SER_ARB_PRIO_EN to give requester 0 priority whenever a new burst starts.
module ser_arbiter
    import ser_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 20,
    parameter int BURST_LEN = 8
) (
    input logic         clk,
    input logic         reset,
    ser_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    state_t           state;
    logic [IW-1:0]    rr_ptr, grant, pick, rr_grant, next_ptr;
    logic [CNT_W-1:0] cnt;
    logic             any, ser_valid, can_take, accept, last;
    logic [WIDTH-1:0] ser_data;
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_valid_i),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .any   (any)
    );
`ifdef SER_ARB_PRIO_EN
    assign pick = bus.req_valid_i[0] ? '0 : rr_grant;
`else
    assign pick = rr_grant;
`endif
    // The output register can take a word when empty or being drained this cycle.
    assign can_take        = !ser_valid || bus.ser_ready_i;
    assign accept          = state == BURST && bus.req_valid_i[grant] && can_take;
    assign last            = accept && cnt == CNT_W'(BURST_LEN - 1);
    assign next_ptr        = grant == IW'(NUM_REQ - 1) ? '0 : grant + 1'b1;
    assign bus.req_ready_o = (state == BURST && can_take) ? NUM_REQ'(1) << grant : '0;
    assign bus.ser_data_o  = ser_data;
    assign bus.ser_valid_o = ser_valid;
    assign bus.grant_o     = grant;
    assign bus.busy_o      = state == BURST;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            ser_valid <= 1'b0;
            ser_data  <= '0;
        end else begin
            if (accept) begin
                ser_data  <= bus.req_data_i[int'(grant)*WIDTH +: WIDTH];
                ser_valid <= 1'b1;
            end else if (bus.ser_ready_i) begin
                ser_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (any) begin
                    state <= BURST;
                    grant <= pick;
                    cnt   <= '0;
                end
            end else if (!bus.req_valid_i[grant] || last) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ser_arbiter.sv
// tb_ser_arbiter: directed vector table plus hand sequences for stall, drop, priority and reset.
module tb_ser_arbiter;
    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic        busy;
        logic [1:0]  grant;
        logic        sv;
        logic [19:0] sd;
        logic [3:0]  rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  valid = '0;
    logic        ready = 1'b1;
    logic [79:0] data;
    logic [15:0] seq [4];
    int          total = 0;
    int          bad = 0;
    vec_t        tbl [12];

    ser_arbiter_if #(.NUM_REQ(4), .WIDTH(20)) b4 ();
    ser_arbiter_if #(.NUM_REQ(4), .WIDTH(20)) b8 ();
    assign b4.req_valid_i = valid;
    assign b4.req_data_i  = data;
    assign b4.ser_ready_i = ready;
    assign b8.req_valid_i = valid;
    assign b8.req_data_i  = data;
    assign b8.ser_ready_i = ready;

    ser_arbiter #(.NUM_REQ(4), .WIDTH(20), .BURST_LEN(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    ser_arbiter #(.NUM_REQ(4), .WIDTH(20), .BURST_LEN(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    always #5 clk = ~clk;

    // Each requester presents {index, sequence number}; the number advances on each accepted word.
    always_comb for (int i = 0; i < 4; i++) data[i*20 +: 20] = {4'(i), seq[i]};
    always @(posedge clk or posedge reset) begin
        if (reset) for (int i = 0; i < 4; i++) seq[i] <= '0;
        else for (int i = 0; i < 4; i++) if (valid[i] && b4.req_ready_o[i]) seq[i] <= seq[i] + 16'd1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk4(input string n, input logic busy, input logic [1:0] grant,
                        input logic sv, input logic [19:0] sd, input logic [3:0] rdy);
        chk({n, ".busy"},  32'(b4.busy_o),      32'(busy));
        chk({n, ".grant"}, 32'(b4.grant_o),     32'(grant));
        chk({n, ".valid"}, 32'(b4.ser_valid_o), 32'(sv));
        chk({n, ".data"},  32'(b4.ser_data_o),  32'(sd));
        chk({n, ".ready"}, 32'(b4.req_ready_o), 32'(rdy));
    endtask

    task automatic do_reset();
        valid = '0;
        ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk4("reset", 0, 0, 0, 20'h0, 4'b0000);
        chk("reset.b8busy", 32'(b8.busy_o), 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0101, 1, 1, 0, 0, 20'h00000, 4'b0001};
        tbl[1]  = '{4'b0101, 1, 1, 0, 1, 20'h00000, 4'b0001};
        tbl[2]  = '{4'b0101, 1, 1, 0, 1, 20'h00001, 4'b0001};
        tbl[3]  = '{4'b0101, 1, 1, 0, 1, 20'h00002, 4'b0001};
        tbl[4]  = '{4'b0101, 1, 0, 0, 1, 20'h00003, 4'b0000};
        tbl[5]  = '{4'b0101, 1, 1, 2, 0, 20'h00003, 4'b0100};
        tbl[6]  = '{4'b0101, 1, 1, 2, 1, 20'h20000, 4'b0100};
        tbl[7]  = '{4'b0101, 1, 1, 2, 1, 20'h20001, 4'b0100};
        tbl[8]  = '{4'b0101, 1, 1, 2, 1, 20'h20002, 4'b0100};
        tbl[9]  = '{4'b0101, 1, 0, 2, 1, 20'h20003, 4'b0000};
        tbl[10] = '{4'b0101, 1, 1, 0, 0, 20'h20003, 4'b0001};
        tbl[11] = '{4'b0101, 1, 1, 0, 1, 20'h00004, 4'b0001};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            valid = tbl[i].valid;
            ready = tbl[i].ready;
            step();
            chk4($sformatf("alt[%0d]", i), tbl[i].busy, tbl[i].grant, tbl[i].sv, tbl[i].sd, tbl[i].rdy);
        end

        // Requester 1 drops after two words on the BURST_LEN=8 instance.
        do_reset();
        valid = 4'b0010;
        step();
        chk("drop.busy0", 32'(b8.busy_o), 1);
        chk("drop.grant0", 32'(b8.grant_o), 1);
        step();
        chk("drop.w0", 32'(b8.ser_data_o), 32'h10000);
        step();
        chk("drop.w1", 32'(b8.ser_data_o), 32'h10001);
        valid = 4'b0000;
        step();
        chk("drop.idle", 32'(b8.busy_o), 0);
        chk("drop.drained", 32'(b8.ser_valid_o), 0);
        chk("drop.rdy", 32'(b8.req_ready_o), 0);
        valid = 4'b0111;
        step();
        chk("drop.next_grant", 32'(b8.grant_o), 2);

        // Serializer stalls five cycles after the first word.
        do_reset();
        valid = 4'b0001;
        step();
        chk4("stall.start", 1, 0, 0, 20'h0, 4'b0001);
        step();
        chk4("stall.w0", 1, 0, 1, 20'h00000, 4'b0001);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk4($sformatf("stall.hold[%0d]", i), 1, 0, 1, 20'h00000, 4'b0000);
        end
        ready = 1'b1;
        step();
        chk4("stall.w1", 1, 0, 1, 20'h00001, 4'b0001);
        step();
        chk4("stall.w2", 1, 0, 1, 20'h00002, 4'b0001);
        step();
        chk4("stall.w3", 0, 0, 1, 20'h00003, 4'b0000);
        step();
        chk4("stall.rearb", 1, 0, 0, 20'h00003, 4'b0001);
        step();
        chk4("stall.w4", 1, 0, 1, 20'h00004, 4'b0001);

        // Bring rr_ptr to 3, then all requesters valid.
        do_reset();
        valid = 4'b0100;
        step();
        valid = 4'b0000;
        step();
        chk("prio.idle", 32'(b4.busy_o), 0);
        valid = 4'b1111;
        step();
        chk("prio.busy", 32'(b4.busy_o), 1);
`ifdef SER_ARB_PRIO_EN
        chk("prio.grant", 32'(b4.grant_o), 0);
`else
        chk("prio.grant", 32'(b4.grant_o), 3);
`endif

        // Asynchronous reset in the middle of a requester-2 burst.
        do_reset();
        valid = 4'b0100;
        step();
        step();
        step();
        step();
        chk4("rst.w2", 1, 2, 1, 20'h20002, 4'b0100);
        #1 reset = 1'b1;
        #1 chk4("rst.async", 0, 0, 0, 20'h0, 4'b0000);
        step();
        chk4("rst.held", 0, 0, 0, 20'h0, 4'b0000);
        reset = 1'b0;
        valid = 4'b0101;
        step();
        chk4("rst.restart", 1, 0, 0, 20'h0, 4'b0001);
        step();
        chk4("rst.first", 1, 0, 1, 20'h00000, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter WIDTH, default 20: word width, equal to the serializer parallel input width.
REQ-003 Parameter BURST_LEN, default 8: maximum words accepted per grant; legal range 1..255.
REQ-004 clk  input  1  clock; all state in this block updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  NUM_REQ  per-requester word-valid.
REQ-007 req_data_i  input  NUM_REQ x WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept; a word transfers when req_valid_i[i] and req_ready_o[i] are both high.
REQ-009 ser_data_o  output  WIDTH  word presented to the serializer.
REQ-010 ser_valid_o  output  1  ser_data_o holds a valid word.
REQ-011 ser_ready_i  input  1  serializer can take a word; a transfer occurs when ser_valid_o and ser_ready_i are both high.
REQ-012 grant_o  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 busy_o  output  1  high while in state BURST.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-015 IDLE->BURST SHALL occur on the first cycle any req_valid_i bit is high; the grant is the first valid requester scanning upward, with wrap, from rr_ptr.
REQ-016 In BURST, req_ready_o[grant_o] SHALL equal (!ser_valid_o || ser_ready_i); all other req_ready_o bits SHALL be 0. In IDLE, all req_ready_o bits SHALL be 0.
REQ-017 An accepted word SHALL load the output register, so ser_data_o and ser_valid_o reflect it one cycle after acceptance (latency 1).
REQ-018 ser_valid_o SHALL clear after a serializer transfer unless a new word is accepted in the same cycle, giving back-to-back throughput of 1 word/cycle.
REQ-019 ser_data_o SHALL stay stable while ser_valid_o is high and ser_ready_i is low.
REQ-020 An 8-bit burst counter SHALL count words accepted in the current BURST and clear on entering BURST.
REQ-021 BURST->IDLE SHALL occur when a word is accepted with counter == BURST_LEN-1, or when req_valid_i[grant_o] is low.
REQ-022 On BURST->IDLE, rr_ptr SHALL become grant_o+1, wrapping modulo NUM_REQ.
REQ-023 A requester dropping valid mid-burst SHALL lose its grant; it SHALL NOT be re-granted before the other valid requesters are served.
REQ-024 The output register SHALL drain independently of the FSM state; a pending word is never discarded.
REQ-025 busy_o SHALL be high exactly while the FSM is in BURST.

Reset
REQ-026 Reset SHALL force: state IDLE, rr_ptr 0, counter 0, grant_o 0, ser_valid_o 0, ser_data_o 0, req_ready_o all 0.
REQ-027 Reset asserted mid-burst SHALL discard any pending output word, with no partial transfer after deassertion.

Configuration
REQ-028 Macro SER_ARB_PRIO_EN: when defined, requester 0 SHALL be granted in IDLE whenever req_valid_i[0] is high, regardless of rr_ptr; requester 0 bursts still advance rr_ptr normally.
REQ-029 Without SER_ARB_PRIO_EN, arbitration SHALL be pure round-robin per REQ-015.

Structure
REQ-030 Package ser_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the burst-counter width constant.
REQ-031 Round-robin selection SHALL live in sub-module rr_pick, which takes the request vector and pointer and returns the grant index and an any-request flag.

Verification
REQ-032 Reqs 0 and 2 continuously valid, BURST_LEN=4, ser_ready_i=1 -> 4 words from req 0, then 4 from req 2, alternating; grant_o toggles 0/2.
REQ-033 Req 1 valid for 2 words then drops, BURST_LEN=8 -> burst ends after 2 words, FSM returns to IDLE, rr_ptr=2.
REQ-034 ser_ready_i held low for 5 cycles mid-burst -> ser_data_o stable, req_ready_o all 0, no word lost or duplicated.
REQ-035 With SER_ARB_PRIO_EN defined, all reqs valid, rr_ptr=3 -> grant_o=0; without the macro -> grant_o=3.
REQ-036 Reset pulsed at word 3 of a burst -> all outputs 0 next cycle; after release, arbitration restarts from requester 0.
